// File: rtl/cpu_session_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cpu_session_ctrl
// Brief    : Session sequencer for main_CPU. Loads the instruction and data
//            memories from a valid/ready stream while the CPU is held in
//            reset, runs the CPU under an optional cycle timeout, then
//            streams a window of data memory out on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_session_ctrl #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int TMO_W  = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   ins_count,
   input  logic [ADDR_W:0]   data_count,
   input  logic [ADDR_W-1:0] dump_base,
   input  logic [ADDR_W:0]   dump_count,
   input  logic [TMO_W-1:0]  timeout,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              cpu_rst,
   output logic              cpu_we_ins,
   output logic              cpu_we_data,
   output logic [ADDR_W-1:0] cpu_add_ins,
   output logic [ADDR_W-1:0] cpu_add_data,
   output logic [DATA_W-1:0] cpu_input_ins,
   output logic [DATA_W-1:0] cpu_input_data,
   input  logic              cpu_done,
   input  logic [DATA_W-1:0] cpu_out,
   output logic              busy,
   output logic              timed_out,
   output logic [TMO_W-1:0]  run_cycles
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_I = 3'd1,
      LOAD_D = 3'd2,
      RUN    = 3'd3,
      DUMP   = 3'd4
   } state_t;

   localparam logic [ADDR_W:0]  c_MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]  c_CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [TMO_W-1:0] c_TMO_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W:0]   r_ins_cnt;
   logic [ADDR_W:0]   r_data_cnt;
   logic [ADDR_W:0]   r_dump_cnt;
   logic [ADDR_W-1:0] r_dump_base;
   logic [TMO_W-1:0]  r_timeout;
   logic [ADDR_W:0]   r_idx;
   logic [ADDR_W:0]   r_rd_idx;
   logic [TMO_W-1:0]  r_run_cycles;
   logic              r_timed_out;
   logic              r_m_valid;
   logic [DATA_W-1:0] r_m_data;

   logic [ADDR_W:0]   w_ins_cl;
   logic [ADDR_W:0]   w_data_cl;
   logic [ADDR_W:0]   w_dump_cl;
   logic [ADDR_W:0]   w_idx_inc;
   logic [TMO_W-1:0]  w_run_inc;
   logic              w_last_i;
   logic              w_last_d;
   logic              w_tmo_hit;
   logic              w_words_left;
   logic              w_m_accept;
   logic              w_m_load;

   // Word counts above the memory depth are limited to the full memory.
   function automatic logic [ADDR_W:0] clamp_cnt(input logic [ADDR_W:0] v);
      return (v > c_MAX_WORDS) ? c_MAX_WORDS : v;
   endfunction

   assign w_ins_cl     = clamp_cnt(ins_count);
   assign w_data_cl    = clamp_cnt(data_count);
   assign w_dump_cl    = clamp_cnt(dump_count);
   assign w_idx_inc    = r_idx + c_CNT_ONE;
   assign w_last_i     = (w_idx_inc == r_ins_cnt);
   assign w_last_d     = (w_idx_inc == r_data_cnt);
   assign w_run_inc    = r_run_cycles + c_TMO_ONE;
   // Fires in the cycle that completes the timeout-th RUN cycle.
   assign w_tmo_hit    = (r_timeout != '0) && (w_run_inc == r_timeout);
   assign w_words_left = (r_rd_idx != r_dump_cnt);
   assign w_m_accept   = r_m_valid && m_ready;
   // Refill the output register whenever it is empty or being drained.
   assign w_m_load     = (r_state == DUMP) && w_words_left && (!r_m_valid || m_ready);

   assign busy       = (r_state != IDLE);
   assign cpu_rst    = rst || (r_state == IDLE) || (r_state == LOAD_I) || (r_state == LOAD_D);
   assign m_valid    = r_m_valid;
   assign m_data     = r_m_data;
   assign timed_out  = r_timed_out;
   assign run_cycles = r_run_cycles;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state decode and the memory-port / load-stream outputs.
   always_comb begin
      w_state_nxt    = r_state;
      s_ready        = 1'b0;
      cpu_we_ins     = 1'b0;
      cpu_add_ins    = '0;
      cpu_input_ins  = '0;
      cpu_we_data    = 1'b0;
      cpu_add_data   = '0;
      cpu_input_data = '0;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (w_ins_cl != '0)       w_state_nxt = LOAD_I;
               else if (w_data_cl != '0) w_state_nxt = LOAD_D;
               else                      w_state_nxt = RUN;
            end
         end
         LOAD_I: begin
            s_ready       = 1'b1;
            cpu_we_ins    = s_valid;
            cpu_add_ins   = r_idx[ADDR_W-1:0];
            cpu_input_ins = s_data;
            if (s_valid && w_last_i)
               w_state_nxt = (r_data_cnt != '0) ? LOAD_D : RUN;
         end
         LOAD_D: begin
            s_ready        = 1'b1;
            cpu_we_data    = s_valid;
            cpu_add_data   = r_idx[ADDR_W-1:0];
            cpu_input_data = s_data;
            if (s_valid && w_last_d)
               w_state_nxt = RUN;
         end
         RUN: begin
            cpu_add_data = r_dump_base;
            if (cpu_done)
               w_state_nxt = (r_dump_cnt != '0) ? DUMP : IDLE;
            else if (w_tmo_hit)
               w_state_nxt = IDLE;
         end
         DUMP: begin
            // Address arithmetic is ADDR_W wide, so the window wraps past the top.
            cpu_add_data = r_dump_base + r_rd_idx[ADDR_W-1:0];
            if (w_m_accept && !w_words_left)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Session parameters, load/dump indices, run counter and output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ins_cnt    <= '0;
         r_data_cnt   <= '0;
         r_dump_cnt   <= '0;
         r_dump_base  <= '0;
         r_timeout    <= '0;
         r_idx        <= '0;
         r_rd_idx     <= '0;
         r_run_cycles <= '0;
         r_timed_out  <= 1'b0;
         r_m_valid    <= 1'b0;
         r_m_data     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_ins_cnt    <= w_ins_cl;
                  r_data_cnt   <= w_data_cl;
                  r_dump_cnt   <= w_dump_cl;
                  r_dump_base  <= dump_base;
                  r_timeout    <= timeout;
                  r_idx        <= '0;
                  r_rd_idx     <= '0;
                  r_run_cycles <= '0;
                  r_timed_out  <= 1'b0;
               end
            end
            LOAD_I: begin
               if (s_valid) r_idx <= w_last_i ? '0 : w_idx_inc;
            end
            LOAD_D: begin
               if (s_valid) r_idx <= w_last_d ? '0 : w_idx_inc;
            end
            RUN: begin
               if (r_run_cycles != '1) r_run_cycles <= w_run_inc;
               if (!cpu_done && w_tmo_hit) r_timed_out <= 1'b1;
            end
            DUMP: begin
               if (w_m_load) begin
                  r_m_data  <= cpu_out;
                  r_m_valid <= 1'b1;
                  r_rd_idx  <= r_rd_idx + c_CNT_ONE;
               end else if (w_m_accept) begin
                  r_m_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cpu_session_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cpu_session_ctrl
// Brief    : Directed bench for cpu_session_ctrl with a behavioural CPU stub
//            (memories, halt after a set number of cycles, one add).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_session_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [10:0] ins_count, data_count, dump_count;
   logic [9:0]  dump_base;
   logic [23:0] timeout;
   logic        s_valid, s_ready;
   logic [31:0] s_data;
   logic        m_valid, m_ready;
   logic [31:0] m_data;
   logic        cpu_rst, cpu_we_ins, cpu_we_data;
   logic [9:0]  cpu_add_ins, cpu_add_data;
   logic [31:0] cpu_input_ins, cpu_input_data;
   logic        cpu_done;
   logic [31:0] cpu_out;
   logic        busy, timed_out;
   logic [23:0] run_cycles;

   int n_tests = 0;
   int n_fail  = 0;

   // CPU stub state
   logic [31:0] mem_i [0:1023];
   logic [31:0] mem_d [0:1023];
   int          cpu_cnt = 0;
   int          halt_after;
   bit          cpu_add_en;

   // Bookkeeping
   logic [31:0] ld_words [0:2047];
   logic [31:0] dq [$];
   logic [9:0]  wq_i [$];
   int          cyc = 0;
   int          last_dwr_cyc, first_run_cyc, run_seen, mv_seen, stall_viol;
   bit          prev_stall;
   logic [31:0] prev_data;

   cpu_session_ctrl dut (
      .clk(clk), .rst(rst), .start(start),
      .ins_count(ins_count), .data_count(data_count),
      .dump_base(dump_base), .dump_count(dump_count), .timeout(timeout),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .cpu_rst(cpu_rst), .cpu_we_ins(cpu_we_ins), .cpu_we_data(cpu_we_data),
      .cpu_add_ins(cpu_add_ins), .cpu_add_data(cpu_add_data),
      .cpu_input_ins(cpu_input_ins), .cpu_input_data(cpu_input_data),
      .cpu_done(cpu_done), .cpu_out(cpu_out),
      .busy(busy), .timed_out(timed_out), .run_cycles(run_cycles)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // CPU stub: memories, cycle counter, and mem_d[0] += mem_d[1] on its first cycle.
   always @(posedge clk) begin
      if (cpu_we_ins)  mem_i[cpu_add_ins]  <= cpu_input_ins;
      if (cpu_we_data) mem_d[cpu_add_data] <= cpu_input_data;
      if (cpu_rst) cpu_cnt <= 0;
      else begin
         cpu_cnt <= cpu_cnt + 1;
         if (cpu_cnt == 0 && cpu_add_en) mem_d[0] <= mem_d[0] + mem_d[1];
      end
   end
   assign cpu_done = !cpu_rst && (halt_after != 0) && (cpu_cnt >= halt_after - 1);
   assign cpu_out  = mem_d[cpu_add_data];

   // Mid-cycle monitor of writes, run cycles and the dump stream.
   always @(negedge clk) begin
      if (!rst) begin
         if (cpu_we_ins)  wq_i.push_back(cpu_add_ins);
         if (cpu_we_data) last_dwr_cyc = cyc;
         if (busy && !cpu_rst) begin
            run_seen++;
            if (first_run_cyc < 0) first_run_cyc = cyc;
         end
         if (m_valid) mv_seen++;
         if (m_valid && m_ready) dq.push_back(m_data);
         if (prev_stall && m_valid && m_data != prev_data) stall_viol++;
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] dqv(input int i);
      return (i < dq.size()) ? dq[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] wqv(input int i);
      return (i < wq_i.size()) ? {22'd0, wq_i[i]} : 32'hDEAD_BEEF;
   endfunction

   task automatic clr();
      dq.delete();
      wq_i.delete();
      last_dwr_cyc  = -1;
      first_run_cyc = -1;
      run_seen      = 0;
      mv_seen       = 0;
      stall_viol    = 0;
   endtask

   task automatic do_start(input int ic, input int dc, input int db, input int dn, input int tmo);
      ins_count  = 11'(ic);
      data_count = 11'(dc);
      dump_base  = 10'(db);
      dump_count = 11'(dn);
      timeout    = 24'(tmo);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic drive_load(input int n, input bit gaps);
      int i = 0;
      int k = 0;
      bit ph = 1'b1;
      while (i < n && k < 3000) begin
         s_valid = gaps ? ph : 1'b1;
         ph      = !ph;
         s_data  = ld_words[i];
         @(negedge clk);
         if (s_valid && s_ready) i++;
         @(posedge clk); #1;
         k++;
      end
      s_valid = 1'b0;
      check("load_accepted", i, n);
   endtask

   task automatic wait_idle(input int budget, input bit stall);
      int n  = 0;
      int st = 0;
      do begin
         @(posedge clk); #1;
         if (stall && dq.size() == 1 && st < 3) begin
            m_ready = 1'b0;
            st++;
         end else m_ready = 1'b1;
         @(negedge clk);
         n++;
      end while (busy && n < budget);
      m_ready = 1'b1;
      check("reach_idle", busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
      ins_count = '0; data_count = '0; dump_count = '0; dump_base = '0; timeout = '0;
      halt_after = 0; cpu_add_en = 1'b0;
      for (int i = 0; i < 2048; i++) ld_words[i] = 32'hC000_0000 + 32'(i);
      clr();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cpu_rst", cpu_rst, 1);
      check("rst_flags", {s_ready, m_valid, busy, timed_out, cpu_we_ins, cpu_we_data}, 0);
      check("rst_m_data", m_data, 0);
      check("rst_run_cycles", run_cycles, 0);
      check("rst_addr_data", {cpu_add_ins, cpu_add_data, cpu_input_ins, cpu_input_data}, 0);
      @(posedge clk); #1 rst = 1'b0;

      // Basic session
      clr(); halt_after = 5; cpu_add_en = 1'b1;
      ld_words[4] = 32'h11; ld_words[5] = 32'h22;
      do_start(4, 2, 0, 2, 0);
      @(negedge clk);
      check("start_busy_ready", {busy, s_ready}, 2'b11);
      @(posedge clk); #1;
      drive_load(6, 1'b0);
      wait_idle(200, 1'b0);
      check("basic_nwr", wq_i.size(), 4);
      for (int i = 0; i < 4; i++) check("basic_ins_addr", wqv(i), i);
      check("basic_mem_i3", mem_i[3], 32'hC000_0003);
      check("basic_rst_fall", first_run_cyc - last_dwr_cyc, 1);
      check("basic_run_cycles", run_cycles, 5);
      check("basic_ndump", dq.size(), 2);
      check("basic_dump0", dqv(0), 32'h33);
      check("basic_dump1", dqv(1), 32'h22);
      check("basic_timed_out", timed_out, 0);

      // Backpressure on both streams
      clr(); halt_after = 2;
      ld_words[3] = 32'h31; ld_words[4] = 32'h32; ld_words[5] = 32'h33;
      do_start(3, 3, 0, 3, 0);
      drive_load(6, 1'b1);
      wait_idle(200, 1'b1);
      check("bp_mem_i2", mem_i[2], 32'hC000_0002);
      check("bp_ndump", dq.size(), 3);
      check("bp_dump0", dqv(0), 32'h63);
      check("bp_dump1", dqv(1), 32'h32);
      check("bp_dump2", dqv(2), 32'h33);
      check("bp_stall_stable", stall_viol, 0);

      // Timeout
      clr(); halt_after = 0; cpu_add_en = 1'b0;
      do_start(1, 0, 0, 2, 100);
      drive_load(1, 1'b0);
      wait_idle(300, 1'b0);
      check("tmo_run_seen", run_seen, 100);
      check("tmo_run_cycles", run_cycles, 100);
      check("tmo_flag", timed_out, 1);
      check("tmo_no_m_valid", mv_seen, 0);

      // Zero counts
      clr(); halt_after = 3;
      do_start(0, 0, 0, 0, 0);
      @(negedge clk);
      check("zero_straight_run", {busy, cpu_rst, s_ready}, 3'b100);
      wait_idle(100, 1'b0);
      check("zero_run_cycles", run_cycles, 3);
      check("zero_no_output", mv_seen, 0);
      check("zero_tmo_cleared", timed_out, 0);

      // Wrapping dump window
      clr(); halt_after = 1;
      mem_d[1022] <= 32'hD000_03FE; mem_d[1023] <= 32'hD000_03FF;
      mem_d[0]    <= 32'hD000_0000; mem_d[1]    <= 32'hD000_0001;
      do_start(0, 0, 1022, 4, 0);
      wait_idle(100, 1'b0);
      check("wrap_ndump", dq.size(), 4);
      check("wrap_d0", dqv(0), 32'hD000_03FE);
      check("wrap_d1", dqv(1), 32'hD000_03FF);
      check("wrap_d2", dqv(2), 32'hD000_0000);
      check("wrap_d3", dqv(3), 32'hD000_0001);

      // Clamp of an oversized instruction count
      clr(); halt_after = 1;
      do_start(2047, 0, 0, 0, 0);
      drive_load(1024, 1'b0);
      @(negedge clk);
      check("clamp_load_closed", {s_ready, cpu_rst}, 2'b00);
      wait_idle(100, 1'b0);
      check("clamp_nwr", wq_i.size(), 1024);
      check("clamp_last_addr", wqv(1023), 1023);
      check("clamp_mem_i_top", mem_i[1023], 32'hC000_03FF);

      // Reset in the middle of LOAD_D
      clr(); halt_after = 2;
      do_start(2, 4, 0, 2, 0);
      drive_load(4, 1'b0);
      rst = 1'b1; #1;
      check("rst_load_d", {busy, cpu_rst, s_ready, cpu_we_data}, 4'b0100);
      @(posedge clk); #1 rst = 1'b0;

      // Reset in the middle of DUMP, with the output stalled
      clr(); halt_after = 1; m_ready = 1'b0;
      do_start(0, 0, 0, 5, 0);
      for (int i = 0; i < 50 && !m_valid; i++) @(negedge clk);
      check("dump_reached", m_valid, 1);
      rst = 1'b1; #1;
      check("rst_dump_flags", {m_valid, busy, cpu_rst}, 3'b001);
      check("rst_dump_data", m_data, 0);
      check("rst_dump_run_cycles", run_cycles, 0);
      @(posedge clk); #1 rst = 1'b0; m_ready = 1'b1;

      // New session works; a start pulse while busy is ignored
      clr(); halt_after = 4;
      ld_words[1] = 32'h77;
      do_start(1, 1, 0, 1, 0);
      drive_load(2, 1'b0);
      do_start(5, 0, 0, 0, 1);
      wait_idle(100, 1'b0);
      check("again_run_cycles", run_cycles, 4);
      check("again_ndump", dq.size(), 1);
      check("again_dump0", dqv(0), 32'h77);
      check("again_tmo", timed_out, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cpu_session_ctrl.md
# cpu_session_ctrl

Session sequencer that owns the program/data load ports, reset and result readout of `main_CPU`. It streams a program image into instruction memory and an initial image into data memory while holding the CPU in reset. It then releases reset and watches `done` under an optional cycle timeout, and finally streams a window of data memory out on a valid/ready port. It sits between the external test/host interface and the CPU, replacing direct host control of `we_ins`/`we_data`/`rst`.

## Interface
- `ADDR_W`, 10, memory word-address width (1024 words).
- `DATA_W`, 32, memory word width.
- `TMO_W`, 24, width of timeout and run-cycle counter.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request to begin a session; sampled only in IDLE.
- `ins_count`  in  ADDR_W+1  instruction words to load; latched at start; values >1024 clamp to 1024.
- `data_count`  in  ADDR_W+1  data words to load; latched and clamped as above.
- `dump_base`  in  ADDR_W  first data address to read out; latched at start.
- `dump_count`  in  ADDR_W+1  words to read out; latched and clamped.
- `timeout`  in  TMO_W  max RUN cycles; 0 = unlimited; latched at start.
- `s_valid` / `s_ready` / `s_data`  in / out / in  1 / 1 / DATA_W  load stream: instruction words first, then data words.
- `m_valid` / `m_ready` / `m_data`  out / in / out  1 / 1 / DATA_W  dump stream.
- `cpu_rst`  out  1  CPU reset.
- `cpu_we_ins`, `cpu_we_data`  out  1  memory write enables.
- `cpu_add_ins`, `cpu_add_data`  out  ADDR_W  CPU memory addresses.
- `cpu_input_ins`, `cpu_input_data`  out  DATA_W  CPU write data.
- `cpu_done`  in  1  CPU halt flag.
- `cpu_out`  in  DATA_W  CPU data-memory read port; asynchronous read of `cpu_add_data` while `cpu_done`=1.
- `busy`  out  1  state ≠ IDLE.
- `timed_out`  out  1  sticky: last session aborted by timeout; cleared on next accepted start.
- `run_cycles`  out  TMO_W  RUN cycles counted in the last or current session, saturating.

## Operation
- States: IDLE, LOAD_I, LOAD_D, RUN, DUMP.
- **IDLE.** On `start`=1, latch the parameters, clear `idx`, `run_cycles` and `timed_out`. Next state is LOAD_I if `ins_count`>0, else LOAD_D if `data_count`>0, else RUN.
- **LOAD_I.**
  - `s_ready`=1. A transfer occurs when `s_valid` & `s_ready`.
  - Combinational outputs: `cpu_we_ins` = `s_valid`; `cpu_add_ins` = `idx`; `cpu_input_ins` = `s_data`.
  - `idx` increments on each transfer.
  - After transfer number `ins_count`: clear `idx`, then go to LOAD_D (if `data_count`>0) or RUN.
- **LOAD_D.** Same as LOAD_I, using `cpu_we_data`, `cpu_add_data` and `cpu_input_data`. After the last transfer, go to RUN.
- **`cpu_rst`** = 1 when `rst` or state ∈ {IDLE, LOAD_I, LOAD_D}; 0 in RUN and DUMP. The CPU stays halted, with its memories intact, through the dump.
- **RUN.**
  - `run_cycles` increments every cycle, saturating at all-ones.
  - Priority 1: if `cpu_done`=1 at a clock edge, go to DUMP, or to IDLE if `dump_count`=0.
  - Priority 2: else if `timeout`≠0 and `run_cycles`+1 = `timeout`, set `timed_out` and go to IDLE without dumping.
  - `cpu_done` is ignored outside RUN.
- **DUMP.**
  - `cpu_add_data` = `dump_base` + `rd_idx`, modulo 1024 (wraps past 1023 to 0).
  - The output register loads `m_data` ← `cpu_out` and sets `m_valid`=1 whenever `m_valid`=0 or (`m_valid` & `m_ready`), while words remain.
  - `rd_idx` increments on each load.
  - After the final accepted word, `m_valid` drops and the state returns to IDLE.
  - `m_data` is held stable while `m_valid` & !`m_ready`.
- Unused write enables are 0 and unused address/data outputs are 0 outside their states. `cpu_add_data` = `dump_base` during RUN.
- **`rst` asserted at any time:** immediate return to IDLE, with all outputs at reset values. A partial load leaves memory contents undefined.

## Timing
- **Reset values:** state IDLE; `cpu_rst`=1; `s_ready`=0; `m_valid`=0; `m_data`=0; `busy`=0; `timed_out`=0; `run_cycles`=0; all `cpu_we`*=0; all `cpu_add`*/`cpu_input`*=0.
- `start` sampled at edge k → `busy`=1 and `s_ready`=1 from k+1.
- Load throughput is 1 word/cycle; memory writes commit at the edge of the transfer.
- Last load transfer at edge j → `cpu_rst`=0 from j+1. The CPU executes its first instruction in cycle j+1.
- `cpu_done` sampled at edge d → DUMP from d+1, first `m_valid` from d+2.
- Dump throughput is 1 word/cycle with `m_ready` held high. `dump_count`=N with `m_ready`=1 completes N cycles after the first `m_valid`.
- Timeout T → IDLE at the edge ending the T-th RUN cycle.

## Test plan
- **Basic session:** load 4 instructions and 2 data words, program halts after 5 cycles, `dump_base`=0, `dump_count`=2 → `cpu_we_ins` pulses at addresses 0–3; `cpu_rst` falls the cycle after the last data word; `run_cycles`=5; `m_data` = the stored results; `busy` drops.
- **Backpressure:** `s_valid` toggling 1/0 and `m_ready` low for 3 cycles mid-dump → no duplicated or lost words; `m_data` stable while stalled.
- **Timeout:** program loops forever, `timeout`=100 → IDLE after exactly 100 RUN cycles; `timed_out`=1; `m_valid` never asserts.
- **Zero counts:** `ins_count`=0 and `data_count`=0 go straight to RUN; `dump_count`=0 with `done` → IDLE with no output.
- **Wrap:** `dump_base`=1022, `dump_count`=4 → addresses 1022, 1023, 0, 1. Clamp: `ins_count`=2047 → loads exactly 1024 words.
- **Reset mid-operation:** `rst` asserted mid-LOAD_D, then later mid-DUMP → immediate reset values. A new `start` then works normally. `start` pulsed while busy is ignored.
